// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package hazard_pkg;

  // Controller state: RUN is normal issue, MEM_WAIT freezes the pipe on a data-memory miss
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF       = 16;

  // Pipeline control bundle: stalls hold a register, clrs load a bubble
  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic exmem_stall;
    logic ifid_clr;
    logic idex_clr;
  } ctl_t;

  // Full freeze of the front of the pipe while data memory is busy
  function automatic ctl_t ctl_freeze();
    ctl_t c;
    c             = '0;
    c.pc_stall    = 1'b1;
    c.ifid_stall  = 1'b1;
    c.idex_stall  = 1'b1;
    c.exmem_stall = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// Latency: wires only.
// Backpressure: the controller's stall outputs are the backpressure to the pipeline.
interface hazard_ctrl_if import hazard_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) ();
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_stall;
  logic             exmem_stall;
  logic             ifid_clr;
  logic             idex_clr;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: presents hazard inputs, consumes control
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_clr, idex_clr,
           mem_err, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    output pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_clr, idex_clr,
           mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
// Latency: count visible one cycle after the inc.
// Backpressure: none; inc while saturated is silently dropped.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] cnt
);
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear wins, otherwise step unless already at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// In-order pipeline hazard controller: load-use interlock, branch flush, memory-wait freeze with timeout.
// Latency: stall/clr are combinational (zero-cycle); counters update one cycle later.
// Backpressure: mem_req without mem_ready freezes PC..EX/MEM until ready or MEM_TIMEOUT wait cycles.
module hazard_ctrl import hazard_pkg::*; #(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);
  localparam int            TW  = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(MEM_TIMEOUT);

  state_e        state_q;
  state_e        state_d;
  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;

  logic load_use;
  ctl_t run_ctl;
  logic run_flush;
  ctl_t ctl;
  logic flush_evt;
  logic err_pulse;
  ctl_t ctl_out;

  // Load-use: EX load whose destination is a live source of ID; x0 never interlocks
  always_comb begin
    load_use = 1'b0;
    if (hz.ex_mem_read && (hz.ex_rd != 5'd0)) begin
      load_use = (hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                 (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd));
    end
  end

  // Normal-issue rules: a taken branch kills the younger IF/ID and ID/EX, else bubble a load-use
  always_comb begin
    run_ctl   = '0;
    run_flush = 1'b0;
    if (hz.ex_branch_taken) begin
      run_ctl.ifid_clr = 1'b1;
      run_ctl.idex_clr = 1'b1;
      run_flush        = 1'b1;
    end else if (load_use) begin
      run_ctl.pc_stall   = 1'b1;
      run_ctl.ifid_stall = 1'b1;
      run_ctl.idex_clr   = 1'b1;
    end
  end

  // FSM next state and control decode; a branch seen while frozen is acted on at release
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    ctl       = '0;
    flush_evt = 1'b0;
    err_pulse = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          ctl     = ctl_freeze();
          state_d = MEM_WAIT;
          tcnt_d  = '0;
        end else begin
          ctl       = run_ctl;
          flush_evt = run_flush;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          ctl       = run_ctl;
          flush_evt = run_flush;
          state_d   = RUN;
        end else if (tcnt_q == TMO) begin
          err_pulse = 1'b1;
          state_d   = RUN;
        end else begin
          ctl    = ctl_freeze();
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and timeout registers; reset aborts any wait without an error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Outputs are forced quiet while reset is held, independent of the inputs
  always_comb begin
    ctl_out = '0;
    if (rst_n) begin
      ctl_out = ctl;
    end
  end

  assign hz.pc_stall    = ctl_out.pc_stall;
  assign hz.ifid_stall  = ctl_out.ifid_stall;
  assign hz.idex_stall  = ctl_out.idex_stall;
  assign hz.exmem_stall = ctl_out.exmem_stall;
  assign hz.ifid_clr    = ctl_out.ifid_clr;
  assign hz.idex_clr    = ctl_out.idex_clr;
  assign hz.mem_err     = err_pulse & rst_n;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctl_out.pc_stall),
    .clear (1'b0),
    .cnt   (hz.stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_evt & rst_n),
    .clear (1'b0),
    .cnt   (hz.flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Latency: expectations checked on the falling edge of the cycle they are driven in.
// Backpressure: n/a.
module tb_hazard_ctrl;
  localparam int CW = 4;

  // Output order: pc, ifid_stall, idex_stall, exmem_stall, ifid_clr, idex_clr, mem_err
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_FRZ  = 7'b1111000;
  localparam logic [6:0] O_LU   = 7'b1100010;
  localparam logic [6:0] O_BR   = 7'b0000110;
  localparam logic [6:0] O_ERR  = 7'b0000001;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mrd;
    logic       br;
    logic       mreq;
    logic       mrdy;
  } stim_t;

  typedef struct packed {
    logic [6:0]    o;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic clk;
  logic rst_n;
  hazard_ctrl_if #(.CNT_W(CW)) hz_if ();

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz_if.slave)
  );

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            mon_n;
  int            checks;
  int            errors;
  logic [CW-1:0] es;
  logic [CW-1:0] ef;
  logic [6:0]    obs;

  assign obs = {hz_if.pc_stall, hz_if.ifid_stall, hz_if.idex_stall, hz_if.exmem_stall,
                hz_if.ifid_clr, hz_if.idex_clr, hz_if.mem_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic stim_t st(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic mrd, input logic br, input logic mreq,
                               input logic mrdy);
    stim_t s;
    s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd;
    s.mrd = mrd; s.br = br; s.mreq = mreq; s.mrdy = mrdy;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    hz_if.id_rs1          = s.rs1;
    hz_if.id_rs2          = s.rs2;
    hz_if.id_use_rs1      = s.u1;
    hz_if.id_use_rs2      = s.u2;
    hz_if.ex_rd           = s.rd;
    hz_if.ex_mem_read     = s.mrd;
    hz_if.ex_branch_taken = s.br;
    hz_if.mem_req         = s.mreq;
    hz_if.mem_ready       = s.mrdy;
  endtask

  // Drive one cycle and queue what it must produce; counters show the total of earlier cycles
  task automatic step(input stim_t s, input logic [6:0] o);
    exp_t e;
    @(posedge clk);
    #1;
    apply(s);
    e.o  = o;
    e.sc = es;
    e.fc = ef;
    sb_q.push_back(e);
    if (o[6] && (es != '1)) es = es + 1'b1;
    if (o[2] && (ef != '1)) ef = ef + 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    apply('0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    es = '0;
    ef = '0;
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      mon_n++;
      chk($sformatf("outs#%0d", mon_n), 32'(obs), 32'(mon_e.o));
      chk($sformatf("stall_cnt#%0d", mon_n), 32'(hz_if.stall_cnt), 32'(mon_e.sc));
      chk($sformatf("flush_cnt#%0d", mon_n), 32'(hz_if.flush_cnt), 32'(mon_e.fc));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t lu1;
    stim_t frz;
    checks = 0;
    errors = 0;
    mon_n  = 0;
    es     = '0;
    ef     = '0;
    rst_n  = 1'b0;
    apply('0);
    lu1 = st(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    frz = st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #3;
    chk("reset_outs", 32'(obs), 32'(O_NONE));
    chk("reset_stall_cnt", 32'(hz_if.stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(hz_if.flush_cnt), 32'd0);
    // Hold reset with a hazard present: outputs must stay quiet
    apply(lu1);
    #1;
    chk("reset_forced", 32'(obs), 32'(O_NONE));
    apply('0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Load-use on rs1, then cleared; rs2 variant; unused sources do not interlock
    step(lu1, O_LU);
    step(st(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0), O_NONE);
    step(st(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0), O_LU);
    step(st(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0), O_NONE);
    step(st(5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0), O_NONE);
    step('0, O_NONE);

    // Branch beats load-use
    do_reset();
    step(st(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0), O_BR);
    step('0, O_NONE);

    // Memory wait: three frozen cycles, release on the fourth
    do_reset();
    repeat (3) step(frz, O_FRZ);
    step(st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1), O_NONE);
    step('0, O_NONE);

    // Branch while waiting is held off, then honoured at release; load-use at release
    do_reset();
    step(frz, O_FRZ);
    step(st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0), O_FRZ);
    step(st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1), O_BR);
    step('0, O_NONE);
    step(frz, O_FRZ);
    step(st(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1), O_LU);
    step('0, O_NONE);

    // Timeout: error in the fifth wait cycle, then back in RUN
    do_reset();
    step(frz, O_FRZ);
    repeat (4) step(frz, O_FRZ);
    step(frz, O_ERR);
    step('0, O_NONE);
    step('0, O_NONE);

    // x0 destination never stalls; counters saturate at all-ones
    do_reset();
    step(st(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), O_NONE);
    step(st(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), O_NONE);
    repeat (20) step(lu1, O_LU);
    step('0, O_NONE);
    repeat (20) step(st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), O_BR);
    step('0, O_NONE);

    // Reset dropped mid-wait: immediate quiet outputs, no error, RUN afterwards
    do_reset();
    repeat (3) step(frz, O_FRZ);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_outs", 32'(obs), 32'(O_NONE));
    chk("midwait_rst_stall_cnt", 32'(hz_if.stall_cnt), 32'd0);
    #4;
    chk("midwait_rst_hold", 32'(obs), 32'(O_NONE));
    apply('0);
    @(negedge clk);
    rst_n = 1'b1;
    es = '0;
    ef = '0;
    step('0, O_NONE);
    step(frz, O_FRZ);
    step(st(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1), O_NONE);
    step('0, O_NONE);

    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
